// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the blocks that drive it.
//   ALU_OP_W     : width of the ALU opcode field
//   OP_*         : ALU opcode encodings (1101 and 1111 are unused; the ALU
//                  returns 0 for them)
//   slot_state_t : occupancy of the one-entry result slot in the arbiter
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_SLL = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_EQL = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_SLT = 4'b0100;
    localparam logic [ALU_OP_W-1:0] OP_UGT = 4'b0101;
    localparam logic [ALU_OP_W-1:0] OP_ULT = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_BP  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_SGT = 4'b1001;
    localparam logic [ALU_OP_W-1:0] OP_LSR = 4'b1010;
    localparam logic [ALU_OP_W-1:0] OP_ASR = 4'b1011;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 4'b1100;
    localparam logic [ALU_OP_W-1:0] OP_AND = 4'b1110;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority picker. The search starts at index
// ptr_i and wraps. The first requesting index wins. All outputs are zero
// while en_i is low.
//   req_i     : request vector
//   ptr_i     : index with highest priority this cycle (must be < N)
//   en_i      : allow a grant
//   gnt_o     : one-hot grant
//   gnt_idx_o : encoded grant index (0 when no grant)
//   gnt_any_o : a grant is active
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_any_o
);

    // One spare bit so ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a value unassigned and infers a latch.
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(N)) begin
                    sum = sum - (IDX_W+1)'(N);
                end
                idx = sum[IDX_W-1:0];
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    gnt_idx_o  = idx;
                end
            end
            gnt_any_o = found;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one external combinational ALU among NUM_REQ requesters. A
// round-robin grant steers the winner's operands to the ALU in the same
// cycle. alu_out is captured into a one-entry result slot and returned to
// that requester with valid/ready handshaking.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   req_valid  : per-requester request valid
//   req_op_1/2 : packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_alu_op : packed 4-bit opcodes, requester i at [i*4 +: 4]
//   req_ready  : one-hot grant; the request is accepted on valid & ready
//   alu_op_1/2 : operand drive to the ALU (0 when no grant)
//   alu_op     : opcode drive to the ALU (0 when no grant)
//   alu_out    : combinational ALU result
//   rsp_valid  : one-hot owner of the held result
//   rsp_data   : held result
//   rsp_ready  : per-requester response accept
//   op_count   : completed responses, wraps
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_op_1,
    input  logic [NUM_REQ*DATA_W-1:0]    req_op_2,
    input  logic [NUM_REQ*ALU_OP_W-1:0]  req_alu_op,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]            alu_op_1,
    output logic [DATA_W-1:0]            alu_op_2,
    output logic [ALU_OP_W-1:0]          alu_op,
    input  logic [DATA_W-1:0]            alu_out,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [CNT_W-1:0]             op_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    slot_state_t        state_q, state_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [IDX_W-1:0]   holder_q, holder_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               rsp_fire;
    logic               can_accept;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;

    // Only the holder's rsp_ready matters. Other requesters' bits are ignored.
    assign rsp_fire   = (state_q == SLOT_FULL) && rsp_ready[holder_q];
    // Draining and refilling the slot in the same cycle gives full throughput.
    assign can_accept = (state_q == SLOT_EMPTY) || rsp_fire;

    // Grant is held off while reset is asserted so req_ready reads 0.
    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .en_i      (can_accept && !rst),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // ---------------- slot FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            state_q <= state_d;
        end
    end

    // ---------------- slot FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (gnt_any) state_d = SLOT_FULL;
            SLOT_FULL:  if (rsp_fire && !gnt_any) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // ---------------- slot FSM: outputs ----------------
    always_comb begin
        req_ready = gnt;
        alu_op_1  = '0;
        alu_op_2  = '0;
        alu_op    = '0;
        if (gnt_any) begin
            alu_op_1 = req_op_1[gnt_idx*DATA_W +: DATA_W];
            alu_op_2 = req_op_2[gnt_idx*DATA_W +: DATA_W];
            alu_op   = req_alu_op[gnt_idx*ALU_OP_W +: ALU_OP_W];
        end
    end

    // ---------------- result slot, pointer and counter ----------------
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        holder_d    = holder_q;
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q;
        if (rsp_fire) begin
            op_count_d  = op_count_q + CNT_W'(1);
            rsp_valid_d = '0;
        end
        // A simultaneous accept overwrites the slot that was just drained.
        if (gnt_any) begin
            rsp_valid_d = gnt;
            rsp_data_d  = alu_out;
            holder_d    = gnt_idx;
            rr_ptr_d    = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            holder_q    <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            holder_q    <= holder_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter. A small behavioural ALU stands in for
// the external ALU. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;

    logic                        clk;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*DATA_W-1:0]   req_op_1;
    logic [NUM_REQ*DATA_W-1:0]   req_op_2;
    logic [NUM_REQ*ALU_OP_W-1:0] req_alu_op;
    logic [NUM_REQ-1:0]          req_ready;
    logic [DATA_W-1:0]           alu_op_1;
    logic [DATA_W-1:0]           alu_op_2;
    logic [ALU_OP_W-1:0]         alu_op;
    logic [DATA_W-1:0]           alu_out;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic [NUM_REQ-1:0]          rsp_ready;
    logic [CNT_W-1:0]            op_count;

    int n_cmp = 0;
    int n_mis = 0;

    alu_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op_1   (req_op_1),
        .req_op_2   (req_op_2),
        .req_alu_op (req_alu_op),
        .req_ready  (req_ready),
        .alu_op_1   (alu_op_1),
        .alu_op_2   (alu_op_2),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    function automatic logic [31:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [3:0]  op);
        logic [31:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << b[4:0];
            OP_EQL:  r = {31'd0, a == b};
            OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            OP_UGT:  r = {31'd0, a > b};
            OP_ULT:  r = {31'd0, a < b};
            OP_BP:   r = b;
            OP_XOR:  r = a ^ b;
            OP_SGT:  r = {31'd0, $signed(a) > $signed(b)};
            OP_LSR:  r = a >> b[4:0];
            OP_ASR:  r = $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always_comb alu_out = alu_model(alu_op_1, alu_op_2, alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        req_valid[i]                 = v;
        req_op_1[i*DATA_W +: DATA_W] = a;
        req_op_2[i*DATA_W +: DATA_W] = b;
        req_alu_op[i*4 +: 4]         = op;
    endtask

    // Inputs change at posedge+1, outputs are sampled at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_op_1   = '0;
        req_op_2   = '0;
        req_alu_op = '0;
        rsp_ready  = '0;

        // ---- reset state, request present but no grant while in reset ----
        tick();
        tick();
        set_req(0, 1'b1, 32'd5, 32'd7, OP_ADD);
        rsp_ready = 4'b1111;
        settle();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data",  rsp_data,       32'h0);
        check("rst_op_count",  32'(op_count),  32'h0);
        check("rst_alu_op_1",  alu_op_1,       32'h0);
        tick();
        rst = 1'b0;

        // ---- single ADD 5+7 from requester 0 ----
        settle();
        check("add_req_ready", 32'(req_ready), 32'h1);
        check("add_alu_op_1",  alu_op_1,       32'd5);
        check("add_alu_op_2",  alu_op_2,       32'd7);
        check("add_alu_op",    32'(alu_op),    32'(OP_ADD));
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, OP_ADD);
        settle();
        check("add_rsp_valid", 32'(rsp_valid), 32'h1);
        check("add_rsp_data",  rsp_data,       32'd12);
        check("add_cnt_pre",   32'(op_count),  32'd0);
        tick();
        settle();
        check("add_cnt",       32'(op_count),  32'd1);
        check("add_drained",   32'(rsp_valid), 32'h0);

        // ---- backpressure: requester 1 SUB 10-3 held, requester 2 waits ----
        // rr_ptr is 1. Non-holder rsp_ready bits are high and must be ignored.
        set_req(1, 1'b1, 32'd10,  32'd3, OP_SUB);
        set_req(2, 1'b1, 32'd100, 32'd1, OP_ADD);
        rsp_ready = 4'b1101;
        settle();
        check("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, OP_ADD);
        for (int c = 0; c < 3; c++) begin
            settle();
            check("bp_hold_valid", 32'(rsp_valid), 32'h2);
            check("bp_hold_data",  rsp_data,       32'd7);
            check("bp_hold_ready", 32'(req_ready), 32'h0);
            check("bp_alu_idle",   alu_op_1,       32'h0);
            tick();
        end
        rsp_ready = 4'b0010;
        settle();
        check("bp_grant2",     32'(req_ready), 32'h4);
        check("bp_grant2_op1", alu_op_1,       32'd100);
        check("bp_still_1",    32'(rsp_valid), 32'h2);
        tick();
        set_req(2, 1'b0, 32'd0, 32'd0, OP_ADD);
        rsp_ready = 4'b0100;
        settle();
        check("bp_rsp2_valid", 32'(rsp_valid), 32'h4);
        check("bp_rsp2_data",  rsp_data,       32'd101);
        check("bp_cnt2",       32'(op_count),  32'd2);
        tick();
        settle();
        check("bp_cnt3",       32'(op_count),  32'd3);
        check("bp_drained",    32'(rsp_valid), 32'h0);

        // ---- signed/unsigned and undefined opcode, requester 3 back-to-back ----
        rsp_ready = 4'b1111;
        set_req(3, 1'b1, 32'hFFFF_FFFF, 32'd1, OP_SLT);
        settle();
        check("slt_grant", 32'(req_ready), 32'h8);
        check("slt_alu_op", 32'(alu_op),   32'(OP_SLT));
        tick();
        set_req(3, 1'b1, 32'd9, 32'd9, 4'b1101);
        settle();
        check("slt_valid",   32'(rsp_valid), 32'h8);
        check("slt_data",    rsp_data,       32'd1);
        check("undef_grant", 32'(req_ready), 32'h8);
        check("undef_op",    32'(alu_op),    32'hD);
        tick();
        set_req(3, 1'b1, 32'hFFFF_FFFF, 32'd1, OP_ULT);
        settle();
        check("undef_valid", 32'(rsp_valid), 32'h8);
        check("undef_data",  rsp_data,       32'd0);
        check("undef_cnt",   32'(op_count),  32'd4);
        tick();
        set_req(3, 1'b0, 32'd0, 32'd0, OP_ADD);
        settle();
        check("ult_valid", 32'(rsp_valid), 32'h8);
        check("ult_data",  rsp_data,       32'd0);
        check("ult_cnt",   32'(op_count),  32'd5);
        tick();
        settle();
        check("ult_drain_cnt", 32'(op_count), 32'd6);

        // ---- round-robin: all valid, bypass op_2 = i, from rr_ptr 0 ----
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b1, 32'hAA, 32'(i), OP_BP);
        end
        settle();
        check("rr_first_grant", 32'(req_ready), 32'h1);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) req_valid = '0;
            settle();
            check("rr_data",  rsp_data,       32'(k % 4));
            check("rr_valid", 32'(rsp_valid), 32'h1 << (k % 4));
            if (k < 7) check("rr_next_grant", 32'(req_ready), 32'h1 << ((k + 1) % 4));
            tick();
        end
        settle();
        check("rr_cnt",     32'(op_count),  32'd14);
        check("rr_drained", 32'(rsp_valid), 32'h0);

        // ---- reset mid-operation: slot full, rr_ptr moved to 3 ----
        rsp_ready = 4'b0000;
        set_req(2, 1'b1, 32'd1, 32'd2, OP_ADD);
        settle();
        check("mid_grant", 32'(req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 32'd0, 32'd0, OP_ADD);
        settle();
        check("mid_full", 32'(rsp_valid), 32'h4);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_cnt",   32'(op_count),  32'd0);
        check("mid_rst_data",  rsp_data,       32'd0);
        set_req(2, 1'b1, 32'd20, 32'd22, OP_ADD);
        set_req(3, 1'b1, 32'd1,  32'd1,  OP_ADD);
        rsp_ready = 4'b1111;
        settle();
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        settle();
        check("post_rst_grant", 32'(req_ready), 32'h4);
        check("post_rst_op1",   alu_op_1,       32'd20);
        tick();
        set_req(2, 1'b0, 32'd0, 32'd0, OP_ADD);
        settle();
        check("post_rst_valid", 32'(rsp_valid), 32'h4);
        check("post_rst_data",  rsp_data,       32'd42);
        check("post_rst_next",  32'(req_ready), 32'h8);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance among NUM_REQ requesters (e.g. execute stage, address-gen unit, debug/CSR unit).
- Performs round-robin grant and drives the ALU operand/opcode inputs.
- Captures alu_out into a one-entry result register and returns it to the granted requester with valid/ready backpressure.
- Sits between the requesters and the ALU; the ALU itself stays external and unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width; must match the ALU.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_op_1  input  NUM_REQ*DATA_W  packed operand 1; requester i occupies bits [i*DATA_W +: DATA_W].
- req_op_2  input  NUM_REQ*DATA_W  packed operand 2, same packing.
- req_alu_op  input  NUM_REQ*4  packed 4-bit ALU opcode.
- req_ready  output  NUM_REQ  one-hot grant; the request is accepted on the cycle req_valid[i] & req_ready[i].
- alu_op_1  output  DATA_W  to ALU op_1.
- alu_op_2  output  DATA_W  to ALU op_2.
- alu_op  output  4  to ALU alu_op.
- alu_out  input  DATA_W  from ALU, combinational result.
- rsp_valid  output  NUM_REQ  one-hot; the result is for requester i.
- rsp_data  output  DATA_W  registered result.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- op_count  output  CNT_W  number of completed responses; wraps.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, op_count=0, rr_ptr=0. The ALU drive outputs are 0 whenever no grant is active.
- Slot state, two states:
  - EMPTY: no held result.
  - FULL: rsp_valid is one-hot and rsp_data is held.
- can_accept = EMPTY, or (FULL and rsp_ready[holder] is asserted this cycle).
- Grant:
  - Combinational and round-robin, starting at index rr_ptr.
  - The first i with req_valid[i] is granted; req_ready[i]=1 only if can_accept.
  - At most one req_ready bit is high. req_ready never depends on rsp_valid of another requester.
- ALU drive:
  - While a grant is active, the ALU inputs carry the granted requester's op_1/op_2/alu_op in the same cycle (zero-latency mux).
  - With no grant, all ALU inputs are 0.
- Accept edge:
  - rsp_data <= alu_out; rsp_valid <= one-hot(granted); state becomes FULL.
  - rr_ptr <= (granted+1) mod NUM_REQ.
- Latency: result visible exactly 1 cycle after acceptance. Back-to-back acceptance is possible every cycle when the holder asserts rsp_ready (full throughput).
- Response edge: on rsp_valid[i] & rsp_ready[i], op_count increments by 1, wrapping at 2^CNT_W.
  - If there is no simultaneous accept, state becomes EMPTY and rsp_valid=0.
  - If there is a simultaneous accept, the slot is overwritten by the new result. No bubble; no loss.
- Stability: while FULL and not accepted, rsp_valid and rsp_data hold stable. rsp_ready bits of non-holders are ignored.
- Request hold: a requester may drop req_valid without acceptance; nothing is captured.
- Round-robin fairness: with all NUM_REQ requesters continuously valid and rsp_ready=1, grants cycle 0,1,2,3,0,… Each requester waits at most NUM_REQ-1 grants.
- Reset mid-operation: the held result is discarded and rr_ptr returns to 0. The first grant after reset deasserts goes to the lowest-index valid requester.
- No decoding of alu_op:
  - Opcodes are passed through unchanged, including undefined ones.
  - For an undefined opcode the ALU returns 0, and that 0 is delivered as a normal response.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU opcode constants: OP_ADD=0000, OP_SUB=0001, OP_SLL=0010, OP_EQL=0011, OP_SLT=0100, OP_UGT=0101, OP_ULT=0110, OP_BP=0111, OP_XOR=1000, OP_SGT=1001, OP_LSR=1010, OP_ASR=1011, OP_OR=1100, OP_AND=1110;
  - the ALU_OP_W=4 constant.
- Sub-module rr_arbiter: parameterised round-robin priority picker. Inputs: request vector, rr_ptr, enable. Output: one-hot grant and encoded index. It is reused elsewhere for bus sharing.

Test Plan:
- Single ADD: req_valid=0001, op_1=5, op_2=7, alu_op=0000, rsp_ready=1 → req_ready=0001 same cycle; next cycle rsp_valid=0001, rsp_data=12; op_count=1.
- Backpressure: requester 1 issues SUB 10-3 with rsp_ready[1]=0 for 3 cycles while requester 2 is valid → rsp_data=7 stays stable and req_ready=0000 for 3 cycles. On the rsp_ready[1]=1 cycle, requester 2 is granted; its result appears the next cycle.
- Round-robin: all four valid with opcode OP_BP and op_2=i, rsp_ready=1111 for 8 cycles → rsp_data sequence 0,1,2,3,0,1,2,3 and op_count=8.
- Signed vs unsigned: requester 3 issues SLT with op_1=0xFFFFFFFF, op_2=1 → 1; then ULT with the same operands → 0.
- Undefined opcode 1101 with op_1=op_2=9 → rsp_valid is asserted and rsp_data=0.
- Reset mid-operation: assert rst asynchronously while FULL → rsp_valid=0, op_count=0 immediately. After release with requesters 2 and 3 valid, requester 2 is granted first.
